mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 64, address width; DATA_WIDTH, 64, data width (only 64 supported); REG_ADDR_W, 5, register address width.
REQ-002 Ports SHALL be:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, synchronous, active-low.
- i_valid  in  1  execute-stage instruction valid.
- i_alu_result  in  DATA_WIDTH  effective address / ALU result.
- i_write_data  in  DATA_WIDTH  store data.
- i_funct3  in  3  access size/sign.
- i_mem_re  in  1  load.
- i_mem_we  in  1  store.
- i_reg_we  in  1  register write enable.
- i_rd_addr  in  REG_ADDR_W  destination register.
- i_result_src  in  3  writeback mux select.
- i_flush  in  1  kill the output-register contents.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  request is a write.
- o_mem_addr  out  ADDR_WIDTH  address with bits [2:0] forced to 0.
- o_mem_wdata  out  DATA_WIDTH  lane-aligned store data.
- o_mem_wstrb  out  DATA_WIDTH/8  byte strobes.
- i_mem_ack  in  1  memory done; i_mem_rdata valid.
- i_mem_rdata  in  DATA_WIDTH  read doubleword.
- o_stall  out  1  hold the upstream stages.
- o_misaligned  out  1  registered misalignment exception pulse.
- o_valid, o_alu_result, o_read_data, o_rd_addr, o_result_src, o_reg_we  out  output-register copies of the result.

Function
REQ-003 The FSM SHALL have two states: IDLE and REQ.
REQ-004 A memory access SHALL be i_valid & (i_mem_re | i_mem_we) & aligned.
REQ-005 In IDLE, a memory access SHALL assert o_stall combinationally and move the FSM to REQ. The address, wdata, wstrb and control SHALL be captured at that edge.
REQ-006 In REQ, o_mem_req SHALL be 1 and all o_mem_* outputs SHALL stay stable until i_mem_ack.
REQ-007 In REQ with i_mem_ack=0, o_stall SHALL be 1.
REQ-008 In REQ with i_mem_ack=1:
- o_stall SHALL be 0.
- The output register SHALL load the extracted load data and the captured control.
- The FSM SHALL return to IDLE.
- Load-use latency SHALL be 1 cycle after ack.
REQ-009 Non-memory valid instructions SHALL pass through the output register in 1 cycle with no stall.
REQ-010 i_valid=0 SHALL load o_valid=0 and o_reg_we=0.
REQ-011 funct3 encoding SHALL be: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU; 111 SHALL be treated as 011.
REQ-012 Stores SHALL replicate the source byte, half or word across all lanes.
REQ-013 Store strobes SHALL be 0x01, 0x03, 0x0F or 0xFF by size, shifted left by addr[2:0].
REQ-014 Loads SHALL shift i_mem_rdata right by addr[2:0]*8, then sign-extend (signed funct3) or zero-extend (U variants) to 64 bits.
REQ-015 Alignment SHALL be required as follows: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
REQ-016 On a misaligned access:
- No request SHALL be issued and there SHALL be no stall.
- o_misaligned SHALL be 1 for one cycle, aligned with the output-register update.
- o_reg_we SHALL be 0 and o_valid SHALL be 1.
REQ-017 i_flush SHALL clear o_valid and o_reg_we at the next edge.
REQ-018 i_flush while in REQ SHALL NOT abort the transaction. The transaction SHALL complete, and its result SHALL load with o_valid=0 and o_reg_we=0.
REQ-019 i_mem_ack while in IDLE SHALL be ignored.

Reset
REQ-020 While i_rstn=0 at a clock edge, the module SHALL reset as follows:
- FSM to IDLE.
- o_mem_req, o_mem_we, o_mem_wstrb, o_valid, o_reg_we and o_misaligned to 0.
- All data, address and rd outputs to 0.
REQ-021 Reset asserted while in REQ SHALL drop o_mem_req at the next edge and discard any later ack.
REQ-022 o_stall SHALL be 0 during reset.

Structure
REQ-023 Package mem_stage_pkg SHALL hold the funct3 size/sign enum, the FSM state enum, and the localparam STRB_W = DATA_WIDTH/8.
REQ-024 Sub-module lsu_align SHALL be purely combinational and SHALL contain the store lane alignment, strobe generation, load extraction/extension and the misalignment check.

Verification
REQ-025 SB, addr 0x105, data 0xAB, ack after 3 cycles -> wstrb 0x20, wdata 0xABAB..AB, addr 0x100, o_stall=1 for 4 cycles.
REQ-026 LH, addr 0x002, rdata 0x0000_0000_8001_0000 -> o_read_data 0xFFFF_FFFF_FFFF_8001; LHU on the same access -> 0x0000_0000_0000_8001.
REQ-027 LW, addr 0x006 -> o_mem_req stays 0, o_misaligned=1 for one cycle, o_reg_we=0, no stall.
REQ-028 Back-to-back ADD, LD (ack 0 wait cycles), ADD -> LD result 1 cycle after ack, both ADDs pass with no stall, order preserved.
REQ-029 i_flush during REQ, then ack -> o_valid=0 and o_reg_we=0; i_rstn=0 during REQ -> o_mem_req=0 next cycle and the late ack is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory-stage load/store unit
//
// Holds the funct3 access encoding, the access-size view of funct3[1:0],
// the request FSM state type and the strobe width.

package mem_stage_pkg;

    localparam int LSU_DATA_W = 64;
    localparam int STRB_W     = LSU_DATA_W / 8;

    // funct3 as seen by loads/stores; F3_DX (111) behaves like F3_D.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110,
        F3_DX = 3'b111
    } funct3_e;

    // Access size is funct3[1:0]; bit 2 only selects zero-extension.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane alignment, strobes, load extraction and alignment check
//
// Ports:
//   i_st_off/i_st_size/i_st_data : store-side byte offset, size and source data
//   i_ld_off/i_ld_funct3/i_ld_rdata : load-side byte offset, funct3 and memory doubleword
//   o_st_wdata/o_st_wstrb         : replicated store data and shifted byte strobes
//   o_misaligned                  : store-side access violates natural alignment
//   o_ld_data                     : extracted and sign/zero-extended load result

module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]            i_st_off,
    input  logic [1:0]            i_st_size,
    input  logic [LSU_DATA_W-1:0] i_st_data,
    input  logic [2:0]            i_ld_off,
    input  logic [2:0]            i_ld_funct3,
    input  logic [LSU_DATA_W-1:0] i_ld_rdata,
    output logic [LSU_DATA_W-1:0] o_st_wdata,
    output logic [STRB_W-1:0]     o_st_wstrb,
    output logic                  o_misaligned,
    output logic [LSU_DATA_W-1:0] o_ld_data
);

    size_e                 st_size;
    size_e                 ld_size;
    logic [STRB_W-1:0]     strb_base;
    logic [LSU_DATA_W-1:0] ld_shifted;
    logic                  ld_signed;

    assign st_size   = size_e'(i_st_size);
    assign ld_size   = size_e'(i_ld_funct3[1:0]);
    assign ld_signed = ~i_ld_funct3[2];

    // Replicating the source across every lane means the strobes alone pick
    // the target bytes; no data shifter is needed on the store path.
    always_comb begin
        o_st_wdata   = i_st_data;
        strb_base    = 8'hFF;
        o_misaligned = 1'b0;
        case (st_size)
            SZ_B: begin
                o_st_wdata   = {8{i_st_data[7:0]}};
                strb_base    = 8'h01;
            end
            SZ_H: begin
                o_st_wdata   = {4{i_st_data[15:0]}};
                strb_base    = 8'h03;
                o_misaligned = i_st_off[0];
            end
            SZ_W: begin
                o_st_wdata   = {2{i_st_data[31:0]}};
                strb_base    = 8'h0F;
                o_misaligned = |i_st_off[1:0];
            end
            default: begin
                o_st_wdata   = i_st_data;
                strb_base    = 8'hFF;
                o_misaligned = |i_st_off;
            end
        endcase
        o_st_wstrb = strb_base << i_st_off;
    end

    assign ld_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = ld_shifted;
        case (ld_size)
            SZ_B:    o_ld_data = {{56{ld_signed & ld_shifted[7]}},  ld_shifted[7:0]};
            SZ_H:    o_ld_data = {{48{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W:    o_ld_data = {{32{ld_signed & ld_shifted[31]}}, ld_shifted[31:0]};
            default: o_ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - pipeline memory stage: single-outstanding load/store unit with output register
//
// Ports:
//   i_clk, i_rstn                  : clock, synchronous active-low reset
//   i_valid .. i_result_src        : execute-stage instruction and control
//   i_flush                        : kill whatever the output register loads next
//   o_mem_* / i_mem_ack/i_mem_rdata: doubleword-aligned memory request/response
//   o_stall                        : hold upstream stages while an access is pending
//   o_misaligned                   : one-cycle exception pulse with the output-register update
//   o_valid .. o_reg_we            : output register toward writeback

module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic [2:0]              i_funct3,
    input  logic                    i_mem_re,
    input  logic                    i_mem_we,
    input  logic                    i_reg_we,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr,
    input  logic [2:0]              i_result_src,
    input  logic                    i_flush,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_stall,
    output logic                    o_misaligned,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_alu_result,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    output logic [REG_ADDR_W-1:0]   o_rd_addr,
    output logic [2:0]              o_result_src,
    output logic                    o_reg_we
);

    lsu_state_e state_q, state_d;

    // Request registers, held stable for the whole REQ state.
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]     mem_wstrb_q, mem_wstrb_d;

    // Control captured with the request, replayed into the output register on ack.
    logic [2:0]            ld_off_q,    ld_off_d;
    logic [2:0]            ld_funct3_q, ld_funct3_d;
    logic [DATA_WIDTH-1:0] cap_alu_q,   cap_alu_d;
    logic [REG_ADDR_W-1:0] cap_rd_q,    cap_rd_d;
    logic [2:0]            cap_src_q,   cap_src_d;
    logic                  cap_reg_we_q, cap_reg_we_d;
    logic                  killed_q,    killed_d;

    // Output register.
    logic                  valid_q,      valid_d;
    logic [DATA_WIDTH-1:0] alu_q,        alu_d;
    logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
    logic [REG_ADDR_W-1:0] rd_q,         rd_d;
    logic [2:0]            src_q,        src_d;
    logic                  reg_we_q,     reg_we_d;
    logic                  misaligned_q, misaligned_d;

    logic                  stall;
    logic                  is_mem;
    logic                  misaligned;
    logic                  mem_access;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [STRB_W-1:0]     st_wstrb;
    logic [DATA_WIDTH-1:0] ld_data;

    lsu_align u_align (
        .i_st_off     (i_alu_result[2:0]),
        .i_st_size    (i_funct3[1:0]),
        .i_st_data    (i_write_data),
        .i_ld_off     (ld_off_q),
        .i_ld_funct3  (ld_funct3_q),
        .i_ld_rdata   (i_mem_rdata),
        .o_st_wdata   (st_wdata),
        .o_st_wstrb   (st_wstrb),
        .o_misaligned (misaligned),
        .o_ld_data    (ld_data)
    );

    assign is_mem     = i_valid & (i_mem_re | i_mem_we);
    assign mem_access = is_mem & ~misaligned;

    always_comb begin
        state_d      = state_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        ld_off_d     = ld_off_q;
        ld_funct3_d  = ld_funct3_q;
        cap_alu_d    = cap_alu_q;
        cap_rd_d     = cap_rd_q;
        cap_src_d    = cap_src_q;
        cap_reg_we_d = cap_reg_we_q;
        killed_d     = killed_q;
        // Output register defaults to a bubble; data fields hold.
        valid_d      = 1'b0;
        reg_we_d     = 1'b0;
        misaligned_d = 1'b0;
        alu_d        = alu_q;
        rdata_d      = rdata_q;
        rd_d         = rd_q;
        src_d        = src_q;
        stall        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_access) begin
                    stall        = 1'b1;
                    state_d      = ST_REQ;
                    mem_we_d     = i_mem_we;
                    mem_addr_d   = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
                    mem_wdata_d  = st_wdata;
                    mem_wstrb_d  = i_mem_we ? st_wstrb : '0;
                    ld_off_d     = i_alu_result[2:0];
                    ld_funct3_d  = i_funct3;
                    cap_alu_d    = i_alu_result;
                    cap_rd_d     = i_rd_addr;
                    cap_src_d    = i_result_src;
                    cap_reg_we_d = i_reg_we;
                    killed_d     = 1'b0;
                end else if (i_valid) begin
                    // Plain ALU ops and misaligned accesses both pass straight through;
                    // a misaligned access never writes its destination.
                    valid_d      = 1'b1;
                    reg_we_d     = i_reg_we & ~is_mem;
                    misaligned_d = is_mem;
                    alu_d        = i_alu_result;
                    rd_d         = i_rd_addr;
                    src_d        = i_result_src;
                end
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    state_d     = ST_IDLE;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    valid_d     = ~killed_q;
                    reg_we_d    = cap_reg_we_q & ~killed_q;
                    alu_d       = cap_alu_q;
                    rdata_d     = ld_data;
                    rd_d        = cap_rd_q;
                    src_d       = cap_src_q;
                end else begin
                    stall = 1'b1;
                    // A flush cannot abort the bus transaction, so remember it
                    // and suppress the result when it finally lands.
                    if (i_flush) begin
                        killed_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_flush) begin
            valid_d      = 1'b0;
            reg_we_d     = 1'b0;
            misaligned_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            ld_off_q     <= '0;
            ld_funct3_q  <= '0;
            cap_alu_q    <= '0;
            cap_rd_q     <= '0;
            cap_src_q    <= '0;
            cap_reg_we_q <= 1'b0;
            killed_q     <= 1'b0;
            valid_q      <= 1'b0;
            alu_q        <= '0;
            rdata_q      <= '0;
            rd_q         <= '0;
            src_q        <= '0;
            reg_we_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            ld_off_q     <= ld_off_d;
            ld_funct3_q  <= ld_funct3_d;
            cap_alu_q    <= cap_alu_d;
            cap_rd_q     <= cap_rd_d;
            cap_src_q    <= cap_src_d;
            cap_reg_we_q <= cap_reg_we_d;
            killed_q     <= killed_d;
            valid_q      <= valid_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
            rd_q         <= rd_d;
            src_q        <= src_d;
            reg_we_q     <= reg_we_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Request is a pure function of the registered state, so reset drops it
    // at the next edge and any ack arriving afterwards finds the FSM idle.
    assign o_mem_req    = (state_q == ST_REQ);
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_mem_wstrb  = mem_wstrb_q;
    assign o_stall      = stall & i_rstn;
    assign o_misaligned = misaligned_q;
    assign o_valid      = valid_q;
    assign o_alu_result = alu_q;
    assign o_read_data  = rdata_q;
    assign o_rd_addr    = rd_q;
    assign o_result_src = src_q;
    assign o_reg_we     = reg_we_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard testbench for mem_stage_lsu

module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        i_rstn;
    logic        i_valid;
    logic [63:0] i_alu_result;
    logic [63:0] i_write_data;
    logic [2:0]  i_funct3;
    logic        i_mem_re;
    logic        i_mem_we;
    logic        i_reg_we;
    logic [4:0]  i_rd_addr;
    logic [2:0]  i_result_src;
    logic        i_flush;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wstrb;
    logic        i_mem_ack;
    logic [63:0] i_mem_rdata;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_valid;
    logic [63:0] o_alu_result;
    logic [63:0] o_read_data;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_result_src;
    logic        o_reg_we;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_alu_result(i_alu_result),
        .i_write_data(i_write_data), .i_funct3(i_funct3), .i_mem_re(i_mem_re),
        .i_mem_we(i_mem_we), .i_reg_we(i_reg_we), .i_rd_addr(i_rd_addr),
        .i_result_src(i_result_src), .i_flush(i_flush), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_stall(o_stall), .o_misaligned(o_misaligned), .o_valid(o_valid),
        .o_alu_result(o_alu_result), .o_read_data(o_read_data), .o_rd_addr(o_rd_addr),
        .o_result_src(o_result_src), .o_reg_we(o_reg_we)
    );

    typedef struct {
        logic        reg_we;
        logic        mis;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic [2:0]  src;
        logic        chk_rdata;
    } out_exp_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        chk_wdata;
    } mem_exp_t;

    out_exp_t oq[$];
    mem_exp_t mq[$];

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int req_cnt = 0;

    logic        req_prev = 1'b0;
    logic        h_we;
    logic [63:0] h_addr;
    logic [63:0] h_wdata;
    logic [7:0]  h_strb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output-register monitor: every valid output must match the queue head.
    always @(negedge clk) begin
        out_exp_t e;
        stall_cnt += (o_stall === 1'b1) ? 1 : 0;
        if (o_valid === 1'b1) begin
            checks++;
            if (oq.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got valid alu=0x%0h rd=%0d with empty queue", o_alu_result, o_rd_addr);
            end else begin
                e = oq.pop_front();
                if (o_reg_we !== e.reg_we || o_misaligned !== e.mis || o_alu_result !== e.alu ||
                    o_rd_addr !== e.rd || o_result_src !== e.src ||
                    (e.chk_rdata && o_read_data !== e.rdata)) begin
                    errors++;
                    $display("FAIL out_entry: got we=%0b mis=%0b alu=0x%0h rd=%0d src=%0d data=0x%0h expected we=%0b mis=%0b alu=0x%0h rd=%0d src=%0d data=0x%0h",
                             o_reg_we, o_misaligned, o_alu_result, o_rd_addr, o_result_src, o_read_data,
                             e.reg_we, e.mis, e.alu, e.rd, e.src, e.rdata);
                end
            end
        end else if (o_misaligned === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL mis_without_valid: got o_misaligned=1 expected 0");
        end
    end

    // Memory monitor: new requests match the queue head, held requests stay stable.
    always @(negedge clk) begin
        mem_exp_t m;
        if (o_mem_req === 1'b1 && !req_prev) begin
            req_cnt++;
            checks++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: got request addr=0x%0h with empty queue", o_mem_addr);
            end else begin
                m = mq.pop_front();
                if (o_mem_we !== m.we || o_mem_addr !== m.addr || o_mem_wstrb !== m.wstrb ||
                    (m.chk_wdata && o_mem_wdata !== m.wdata)) begin
                    errors++;
                    $display("FAIL mem_req: got we=%0b addr=0x%0h wdata=0x%0h strb=0x%0h expected we=%0b addr=0x%0h wdata=0x%0h strb=0x%0h",
                             o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, m.we, m.addr, m.wdata, m.wstrb);
                end
            end
            h_we = o_mem_we; h_addr = o_mem_addr; h_wdata = o_mem_wdata; h_strb = o_mem_wstrb;
        end else if (o_mem_req === 1'b1) begin
            checks++;
            if (o_mem_we !== h_we || o_mem_addr !== h_addr || o_mem_wdata !== h_wdata || o_mem_wstrb !== h_strb) begin
                errors++;
                $display("FAIL mem_stable: got addr=0x%0h strb=0x%0h expected addr=0x%0h strb=0x%0h",
                         o_mem_addr, o_mem_wstrb, h_addr, h_strb);
            end
        end
        req_prev = (o_mem_req === 1'b1);
    end

    task automatic idle_inputs();
        i_valid = 1'b0; i_mem_re = 1'b0; i_mem_we = 1'b0; i_reg_we = 1'b0;
        i_funct3 = 3'd0; i_alu_result = 64'd0; i_write_data = 64'd0;
        i_rd_addr = 5'd0; i_result_src = 3'd0; i_flush = 1'b0;
    endtask

    task automatic alu_op(input logic [63:0] alu, input logic [4:0] rd);
        int s0;
        i_valid = 1'b1; i_mem_re = 1'b0; i_mem_we = 1'b0; i_reg_we = 1'b1;
        i_funct3 = 3'd0; i_alu_result = alu; i_write_data = 64'd0;
        i_rd_addr = rd; i_result_src = 3'd0; i_flush = 1'b0;
        oq.push_back('{1'b1, 1'b0, alu, 64'd0, rd, 3'd0, 1'b0});
        s0 = stall_cnt;
        @(posedge clk) #1;
        check("alu_no_stall", 64'(stall_cnt - s0), 64'd0);
    endtask

    task automatic mem_op(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] exp_wd, input logic [7:0] exp_strb,
                          input logic [63:0] rdata, input int wait_n, input logic [63:0] exp_rd,
                          input logic [4:0] rd, input int exp_stall);
        int s0;
        i_valid = 1'b1; i_mem_re = !we; i_mem_we = we; i_reg_we = !we;
        i_funct3 = f3; i_alu_result = addr; i_write_data = wd;
        i_rd_addr = rd; i_result_src = 3'd1; i_flush = 1'b0;
        mq.push_back('{we, {addr[63:3], 3'b000}, exp_wd, (we ? exp_strb : 8'h00), we});
        oq.push_back('{!we, 1'b0, addr, exp_rd, rd, 3'd1, !we});
        s0 = stall_cnt;
        @(posedge clk) #1;
        check("req_up", 64'(o_mem_req), 64'd1);
        repeat (wait_n) @(posedge clk) #1;
        i_mem_ack = 1'b1; i_mem_rdata = rdata;
        @(posedge clk) #1;
        i_mem_ack = 1'b0; i_mem_rdata = 64'd0;
        check("result_after_ack", 64'(o_valid), 64'd1);
        if (!we) check("load_data", o_read_data, exp_rd);
        check("stall_cycles", 64'(stall_cnt - s0), 64'(exp_stall));
    endtask

    task automatic mis_op(input logic we, input logic [2:0] f3, input logic [63:0] addr, input logic [4:0] rd);
        int s0;
        int r0;
        i_valid = 1'b1; i_mem_re = !we; i_mem_we = we; i_reg_we = !we;
        i_funct3 = f3; i_alu_result = addr; i_write_data = 64'h55;
        i_rd_addr = rd; i_result_src = 3'd1; i_flush = 1'b0;
        oq.push_back('{1'b0, 1'b1, addr, 64'd0, rd, 3'd1, 1'b0});
        s0 = stall_cnt; r0 = req_cnt;
        @(posedge clk) #1;
        check("mis_pulse", {o_misaligned, o_valid, o_reg_we}, 64'b110);
        idle_inputs();
        @(posedge clk) #1;
        check("mis_one_cycle", 64'(o_misaligned), 64'd0);
        check("mis_no_req_no_stall", {32'(req_cnt - r0), 32'(stall_cnt - s0)}, 64'd0);
    endtask

    initial begin
        i_rstn = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 64'd0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {o_mem_req, o_mem_we, o_mem_wstrb, o_valid, o_reg_we, o_misaligned, o_stall},
              64'd0);
        check("reset_data", o_read_data | o_alu_result | o_mem_addr | o_mem_wdata | 64'(o_rd_addr), 64'd0);
        i_rstn = 1'b1;
        @(posedge clk) #1;

        // Stores: lane replication and strobes
        mem_op(1'b1, 3'b000, 64'h105, 64'hAB, 64'hABAB_ABAB_ABAB_ABAB, 8'h20, 64'd0, 3, 64'd0, 5'd0, 4);
        mem_op(1'b1, 3'b001, 64'h006, 64'hBEEF, 64'hBEEF_BEEF_BEEF_BEEF, 8'hC0, 64'd0, 1, 64'd0, 5'd0, 2);
        mem_op(1'b1, 3'b010, 64'h104, 64'hDEAD_0000_1234_5678, 64'h1234_5678_1234_5678, 8'hF0, 64'd0, 0, 64'd0, 5'd0, 1);
        mem_op(1'b1, 3'b011, 64'h008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 2, 64'd0, 5'd0, 3);

        // Loads: extraction and extension
        mem_op(1'b0, 3'b001, 64'h002, 64'd0, 64'd0, 8'h00, 64'h0000_0000_8001_0000, 1, 64'hFFFF_FFFF_FFFF_8001, 5'd5, 2);
        mem_op(1'b0, 3'b101, 64'h002, 64'd0, 64'd0, 8'h00, 64'h0000_0000_8001_0000, 1, 64'h0000_0000_0000_8001, 5'd6, 2);
        mem_op(1'b0, 3'b000, 64'h00F, 64'd0, 64'd0, 8'h00, 64'h80AA_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1);
        mem_op(1'b0, 3'b100, 64'h00F, 64'd0, 64'd0, 8'h00, 64'h80AA_0000_0000_0000, 0, 64'h0000_0000_0000_0080, 5'd8, 1);
        mem_op(1'b0, 3'b010, 64'h004, 64'd0, 64'd0, 8'h00, 64'h89AB_CDEF_0000_0000, 2, 64'hFFFF_FFFF_89AB_CDEF, 5'd9, 3);
        mem_op(1'b0, 3'b110, 64'h004, 64'd0, 64'd0, 8'h00, 64'h89AB_CDEF_0000_0000, 0, 64'h0000_0000_89AB_CDEF, 5'd10, 1);
        mem_op(1'b0, 3'b111, 64'h010, 64'd0, 64'd0, 8'h00, 64'hFEDC_BA98_7654_3210, 1, 64'hFEDC_BA98_7654_3210, 5'd11, 2);

        // Misaligned accesses
        mis_op(1'b0, 3'b010, 64'h006, 5'd12);
        mis_op(1'b0, 3'b001, 64'h001, 5'd13);
        mis_op(1'b1, 3'b011, 64'h004, 5'd0);

        // Back-to-back ADD, LD, ADD
        alu_op(64'h11, 5'd1);
        mem_op(1'b0, 3'b011, 64'h008, 64'd0, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0, 64'h1122_3344_5566_7788, 5'd3, 1);
        alu_op(64'h22, 5'd2);

        // Flush on a pass-through op
        i_flush = 1'b1;
        i_valid = 1'b1; i_reg_we = 1'b1; i_alu_result = 64'h33; i_rd_addr = 5'd4;
        @(posedge clk) #1;
        check("flush_alu", {o_valid, o_reg_we}, 64'd0);
        idle_inputs();

        // Flush during REQ: transaction completes, result suppressed
        i_valid = 1'b1; i_mem_re = 1'b1; i_reg_we = 1'b1; i_funct3 = 3'b011;
        i_alu_result = 64'h20; i_rd_addr = 5'd14; i_result_src = 3'd1;
        mq.push_back('{1'b0, 64'h20, 64'd0, 8'h00, 1'b0});
        @(posedge clk) #1;
        i_flush = 1'b1;
        @(posedge clk) #1;
        i_flush = 1'b0;
        check("flush_req_held", 64'(o_mem_req), 64'd1);
        i_mem_ack = 1'b1; i_mem_rdata = 64'hCAFE;
        @(posedge clk) #1;
        i_mem_ack = 1'b0;
        check("flush_req_result", {o_valid, o_reg_we, o_mem_req}, 64'd0);
        idle_inputs();
        @(posedge clk) #1;

        // Reset during REQ: request drops, late ack ignored
        i_valid = 1'b1; i_mem_re = 1'b1; i_reg_we = 1'b1; i_funct3 = 3'b011;
        i_alu_result = 64'h30; i_rd_addr = 5'd15; i_result_src = 3'd1;
        mq.push_back('{1'b0, 64'h30, 64'd0, 8'h00, 1'b0});
        @(posedge clk) #1;
        check("rst_req_up", 64'(o_mem_req), 64'd1);
        i_rstn = 1'b0;
        #1;
        check("stall_in_reset", 64'(o_stall), 64'd0);
        @(posedge clk) #1;
        check("rst_req_drop", 64'(o_mem_req), 64'd0);
        i_rstn = 1'b1;
        idle_inputs();
        i_mem_ack = 1'b1; i_mem_rdata = 64'hBAD;
        @(posedge clk) #1;
        i_mem_ack = 1'b0;
        check("late_ack_ignored", {o_valid, o_reg_we, o_mem_req, o_stall}, 64'd0);
        alu_op(64'h44, 5'd16);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        check("out_queue_drained", 64'(oq.size()), 64'd0);
        check("mem_queue_drained", 64'(mq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
